pong_score_tx: RTL and testbench
================================

# pong_score_tx

UART transmitter that reports pong game state to the host PC over RS-232, the return path complementing the serial receiver that carries paddle positions into the game. On a request strobe it snapshots both scores plus an event code and serialises a fixed 4-byte packet as 8N1 frames: header, packed scores, event, XOR checksum. It sits in the 25 MHz domain next to the game logic, which drives `send` on point scored or paddle hit.

## Interface
- `CLKS_PER_BIT`, 217: clock cycles per UART bit (25 MHz / 115200 baud); must be ≥ 2.
- `HEADER`, 8'hA5: packet start byte.

- `clk`  in  1  system clock (25 MHz game clock).
- `reset`  in  1  synchronous, active-high reset.
- `send`  in  1  packet request; sampled every rising edge, level-qualified, one cycle wide is sufficient.
- `score_left`  in  4  left score, 0–9 nominal; 10–15 transmitted unmodified.
- `score_right`  in  4  right score, same rules.
- `event_code`  in  4  game event (0 none, 1 left point, 2 right point, 3 paddle hit, others reserved).
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a packet is on the line.
- `done`  out  1  one-cycle pulse after the last stop bit of a packet.

## Operation
- Packet bytes, in order: B0 = `HEADER`; B1 = {score_left, score_right}; B2 = {4'h0, event_code}; B3 = B0 ^ B1 ^ B2.
- Each byte is framed as start bit (0), 8 data bits LSB first, stop bit (1). Bytes go back-to-back with no idle gap.
- FSM states and transitions:
  - IDLE: `tx`=1. Leaves on `send` or `pending`.
  - START
  - DATA: bit index 0–7.
  - STOP: byte index 0–3. After STOP of B3, returns to IDLE.
- Payload is captured in the accepting cycle. Inputs are don't-care afterwards.
- `send` while busy sets `pending` and captures the current inputs into a shadow register. Later sends during the same packet overwrite the shadow (last wins, at most one queued packet).
- In IDLE with `pending` set, the shadow is loaded and `pending` is cleared.
- `send` in IDLE with `pending` also set starts one packet using the live inputs and clears `pending`.
- Baud counter counts 0..CLKS_PER_BIT-1 per bit. Bit and byte counters advance on counter terminal. No fractional-baud correction.
- `reset`:
  - Outputs: `tx`=1, `busy`=0, `done`=0.
  - State: IDLE, `pending`=0, all counters 0.
  - Mid-packet reset abandons the frame: `tx` is high from the cycle after reset, and no `done` is emitted.
- Reset has priority over `send` in the same cycle.

## Timing
- `send` sampled high at edge k in IDLE: `tx`=0 and `busy`=1 from cycle k+1.
- Each bit holds exactly CLKS_PER_BIT cycles. The packet occupies 40·CLKS_PER_BIT cycles, from k+1 to k+40·CLKS_PER_BIT.
- In cycle k+40·CLKS_PER_BIT+1 the FSM is in IDLE: `done`=1, `busy`=0, `tx`=1.
  - If `pending` is set, or `send` is high, at that edge, the next start bit begins in the following cycle.
  - Minimum inter-packet idle is therefore one cycle.
- `busy` and `tx` are registered outputs with no combinational path from inputs.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset release: `tx`=1, `busy`=0, `done`=0; `reset` high for 3 cycles while `send`=1 → no start bit.
- Single packet: scores 3/7, event 2, one-cycle `send` → decoded bytes A5, 37, 02, 90. Start bit in the cycle after `send`. `done` pulses exactly 161 cycles after the `send` edge, `busy` low in that cycle.
- Input snapshot: change the scores to 9/9 one cycle after `send` → packet still carries 37 and checksum 90.
- Queueing: during a packet, `send` with scores 1/0 event 1, then `send` with 2/0 event 1 → exactly one extra packet A5, 20, 01, 84, starting 1 cycle after `done`. No third packet.
- Mid-packet reset: assert `reset` during DATA of B1 → `tx`=1 next cycle, `busy`=0, no `done`. A new `send` then yields a complete, correct packet.
- Bit timing: every `tx` level run is a multiple of 4 cycles. Stop bits are high and start bits low at byte offsets 0, 40, 80, 120 cycles.

Source files
------------

// File: rtl/pong_score_tx_if.sv
// Game-side bundle for the pong score transmitter: packet request, snapshot
// inputs and the serial line/status returned to the game logic.
interface pong_score_tx_if;
  logic       send;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic [3:0] event_code;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output send, score_left, score_right, event_code,
    input  tx, busy, done
  );

  modport slave (
    input  send, score_left, score_right, event_code,
    output tx, busy, done
  );
endinterface

// File: rtl/pong_score_tx.sv
// Serialises a 4-byte pong state packet (header, scores, event, XOR checksum)
// as back-to-back 8N1 UART frames, with one queued request held in a shadow.
module pong_score_tx #(
  parameter int          CLKS_PER_BIT = 217,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input logic           clk,
  input logic           reset,
  pong_score_tx_if.slave bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] baud_r, baud_s;
  logic [2:0]    bit_r, bit_s;
  logic [1:0]    byte_r, byte_s;
  logic [11:0]   pkt_r, pkt_s;
  logic [11:0]   shadow_r, shadow_s;
  logic          pending_r, pending_s;
  logic          tx_r, tx_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          baud_end_s;
  logic [7:0]    byte_val_s;

  function automatic logic [7:0] checksum(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2);
    checksum = b0 ^ b1 ^ b2;
  endfunction

  // Payload holds only {score_left, score_right, event_code}; header and checksum derive from it.
  function automatic logic [7:0] packet_byte(input logic [11:0] pkt, input logic [1:0] idx);
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] res;
    b1 = pkt[11:4];
    b2 = {4'h0, pkt[3:0]};
    case (idx)
      2'd0:    res = HEADER;
      2'd1:    res = b1;
      2'd2:    res = b2;
      2'd3:    res = checksum(HEADER, b1, b2);
      default: res = HEADER;
    endcase
    packet_byte = res;
  endfunction

  // Next-state, counter, queue and output decode
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r;
    bit_s      = bit_r;
    byte_s     = byte_r;
    pkt_s      = pkt_r;
    shadow_s   = shadow_r;
    pending_s  = pending_r;
    done_s     = 1'b0;
    tx_s       = 1'b1;
    baud_end_s = (baud_r == CW'(CLKS_PER_BIT - 1));

    if ((state_r != IDLE) && bus.send) begin
      shadow_s  = {bus.score_left, bus.score_right, bus.event_code};
      pending_s = 1'b1;
    end else begin
      shadow_s = shadow_r;
    end

    case (state_r)
      IDLE: begin
        baud_s = '0;
        bit_s  = 3'd0;
        byte_s = 2'd0;
        // A live request beats the queued one and discards it.
        if (bus.send) begin
          pkt_s     = {bus.score_left, bus.score_right, bus.event_code};
          pending_s = 1'b0;
          state_s   = START;
        end else if (pending_r) begin
          pkt_s     = shadow_r;
          pending_s = 1'b0;
          state_s   = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          baud_s  = '0;
          bit_s   = 3'd0;
          state_s = DATA;
        end else begin
          baud_s = baud_r + CW'(1);
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_s = '0;
          if (bit_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + CW'(1);
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_s = '0;
          if (byte_r == 2'd3) begin
            byte_s  = 2'd0;
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            byte_s  = byte_r + 2'd1;
            state_s = START;
          end
        end else begin
          baud_s = baud_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Line level is decoded from the next state so tx leaves a flop aligned with state_r.
    byte_val_s = packet_byte(pkt_s, byte_s);
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = byte_val_s[bit_s];
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, counters, payload and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      baud_r    <= '0;
      bit_r     <= 3'd0;
      byte_r    <= 2'd0;
      pkt_r     <= 12'h000;
      shadow_r  <= 12'h000;
      pending_r <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      baud_r    <= baud_s;
      bit_r     <= bit_s;
      byte_r    <= byte_s;
      pkt_r     <= pkt_s;
      shadow_r  <= shadow_s;
      pending_r <= pending_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign bus.tx   = tx_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule

// File: tb/tb_pong_score_tx.sv
// Directed bench for pong_score_tx at CLKS_PER_BIT=4: reset, single packet,
// input snapshot, queueing, mid-packet reset and bit timing.
module tb_pong_score_tx;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic tx_log [0:159];
  int   busy_low;
  int   done_hi;

  pong_score_tx_if bus ();

  pong_score_tx #(.CLKS_PER_BIT(4), .HEADER(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge of the first start-bit cycle.
  task automatic send_pkt(input logic [3:0] l, input logic [3:0] r, input logic [3:0] e);
    bus.score_left  = l;
    bus.score_right = r;
    bus.event_code  = e;
    bus.send        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.send = 1'b0;
    check("start_tx", {31'd0, bus.tx}, 32'd0);
    check("start_busy", {31'd0, bus.busy}, 32'd1);
  endtask

  // Samples 160 cycles starting with the current one; optionally queues two requests.
  task automatic capture(input bit inject);
    busy_low = 0;
    done_hi  = 0;
    for (int c = 0; c < 160; c++) begin
      if (c > 0) @(negedge clk);
      tx_log[c] = bus.tx;
      if (!bus.busy) busy_low++;
      if (bus.done) done_hi++;
      if (inject) begin
        if (c == 50) begin
          bus.send = 1'b1; bus.score_left = 4'd1; bus.score_right = 4'd0; bus.event_code = 4'd1;
        end else if (c == 90) begin
          bus.send = 1'b1; bus.score_left = 4'd2; bus.score_right = 4'd0; bus.event_code = 4'd1;
        end else if (c == 51 || c == 91) begin
          bus.send = 1'b0; bus.score_left = 4'd9; bus.score_right = 4'd9; bus.event_code = 4'd9;
        end
      end
    end
    check("pkt_busy_low_cycles", busy_low, 32'd0);
    check("pkt_done_early", done_hi, 32'd0);
  endtask

  task automatic check_packet(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3);
    logic [7:0] expv [0:3];
    logic [7:0] got;
    int bad_cells;
    int bad_runs;
    int run;
    expv[0] = 8'hA5; expv[1] = e1; expv[2] = e2; expv[3] = e3;
    for (int i = 0; i < 4; i++) begin
      got = 8'h00;
      for (int j = 0; j < 8; j++) got[j] = tx_log[40*i + 4 + 4*j + 1];
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, expv[i]});
      check($sformatf("%s_start%0d", tag, i), {31'd0, tx_log[40*i]}, 32'd0);
      check($sformatf("%s_stop%0d", tag, i), {31'd0, tx_log[40*i + 39]}, 32'd1);
    end
    bad_cells = 0;
    for (int c = 0; c < 40; c++)
      for (int s = 1; s < 4; s++)
        if (tx_log[4*c + s] !== tx_log[4*c]) bad_cells++;
    check({tag, "_cell_hold"}, bad_cells, 32'd0);
    bad_runs = 0;
    run = 1;
    for (int c = 1; c < 160; c++) begin
      if (tx_log[c] === tx_log[c-1]) run++;
      else begin
        if (run % 4 != 0) bad_runs++;
        run = 1;
      end
    end
    if (run % 4 != 0) bad_runs++;
    check({tag, "_run_len"}, bad_runs, 32'd0);
  endtask

  task automatic check_done(input string tag);
    @(negedge clk);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_done_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done_tx"}, {31'd0, bus.tx}, 32'd1);
  endtask

  initial begin
    int cnt;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.send = 1'b1;
    bus.score_left = 4'd3; bus.score_right = 4'd7; bus.event_code = 4'd2;

    // Reset dominates send
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {31'd0, bus.tx}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    bus.send = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) cnt++;
    end
    check("rst_no_start", cnt, 32'd0);

    // Single packet 3/7 event 2
    send_pkt(4'd3, 4'd7, 4'd2);
    capture(1'b0);
    check_packet("single", 8'h37, 8'h02, 8'h90);
    check_done("single");
    @(negedge clk);
    check("single_done_once", {31'd0, bus.done}, 32'd0);
    repeat (3) @(negedge clk);

    // Snapshot: inputs change right after the accepting edge
    bus.score_left = 4'd3; bus.score_right = 4'd7; bus.event_code = 4'd2;
    bus.send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.send = 1'b0;
    bus.score_left = 4'd9; bus.score_right = 4'd9; bus.event_code = 4'd9;
    capture(1'b0);
    check_packet("snap", 8'h37, 8'h02, 8'h90);
    check_done("snap");
    repeat (3) @(negedge clk);

    // Queueing: two requests during a packet, last wins
    send_pkt(4'd3, 4'd7, 4'd2);
    capture(1'b1);
    check_packet("qfirst", 8'h37, 8'h02, 8'h90);
    check_done("qfirst");
    @(negedge clk);
    check("queued_start_tx", {31'd0, bus.tx}, 32'd0);
    check("queued_start_busy", {31'd0, bus.busy}, 32'd1);
    capture(1'b0);
    check_packet("qsecond", 8'h20, 8'h01, 8'h84);
    check_done("qsecond");
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) cnt++;
    end
    check("no_third_packet", cnt, 32'd0);

    // Mid-packet reset during B1 data bits
    send_pkt(4'd3, 4'd7, 4'd2);
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", {31'd0, bus.tx}, 32'd1);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) cnt++;
    end
    check("midrst_quiet", cnt, 32'd0);
    send_pkt(4'd5, 4'd4, 4'd3);
    capture(1'b0);
    check_packet("after_rst", 8'h54, 8'h03, 8'hF2);
    check_done("after_rst");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
